// File: rtl/imm_gen_pkg.sv
// Shared encodings for the immediate-decode stage: RV opcodes, format codes
// carried on out_fmt, and the held-entry count of the skid buffer.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_Z     = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor: decodes the opcode, builds the
// XLEN-wide extended immediate, and flags opcodes/shamts illegal for XLEN.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_RV64I = (XLEN == 64)
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    localparam bit IS_RV32 = (XLEN == 32);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic            is_shift_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_s_s;
    logic [XLEN-1:0] imm_b_s;
    logic [XLEN-1:0] imm_j_s;
    logic [XLEN-1:0] imm_u_s;
    logic [XLEN-1:0] shamt6_s;
    logic [XLEN-1:0] shamt5_s;
    logic [XLEN-1:0] zimm_s;

    assign opcode_s   = instr_i[6:0];
    assign funct3_s   = instr_i[14:12];
    assign is_shift_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);

    // Signed size casts sign-extend; unsigned ones zero-extend.
    assign imm_i_s  = XLEN'($signed(instr_i[31:20]));
    assign imm_s_s  = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_b_s  = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                     instr_i[11:8], 1'b0}));
    assign imm_j_s  = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                     instr_i[30:21], 1'b0}));
    assign imm_u_s  = XLEN'($signed({instr_i[31:12], 12'b0}));
    assign shamt6_s = XLEN'(instr_i[25:20]);
    assign shamt5_s = XLEN'(instr_i[24:20]);
    assign zimm_s   = XLEN'(instr_i[19:15]);

    // Opcode decode selecting immediate form, format code and legality.
    always_comb begin
        imm_o     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (opcode_s)
            OPC_OP_IMM: begin
                if (is_shift_s) begin
                    imm_o     = shamt6_s;
                    fmt_o     = FMT_SHAMT;
                    illegal_o = IS_RV32 && instr_i[25];
                end else begin
                    imm_o = imm_i_s;
                    fmt_o = FMT_I;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                imm_o = imm_i_s;
                fmt_o = FMT_I;
            end
            OPC_OP_IMM_32: begin
                if (!EN_RV64I) begin
                    illegal_o = 1'b1;
                end else if (is_shift_s) begin
                    imm_o     = shamt5_s;
                    fmt_o     = FMT_SHAMT;
                    illegal_o = instr_i[25];
                end else begin
                    imm_o = imm_i_s;
                    fmt_o = FMT_I;
                end
            end
            OPC_STORE: begin
                imm_o = imm_s_s;
                fmt_o = FMT_S;
            end
            OPC_BRANCH: begin
                imm_o = imm_b_s;
                fmt_o = FMT_B;
            end
            OPC_JAL: begin
                imm_o = imm_j_s;
                fmt_o = FMT_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_o = imm_u_s;
                fmt_o = FMT_U;
            end
            OPC_SYSTEM: begin
                if (funct3_s[2]) begin
                    imm_o = zimm_s;
                    fmt_o = FMT_Z;
                end else begin
                    imm_o = '0;
                    fmt_o = FMT_NONE;
                end
            end
            OPC_OP, OPC_FENCE: begin
                imm_o = '0;
                fmt_o = FMT_NONE;
            end
            OPC_OP_32: begin
                illegal_o = !EN_RV64I;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with valid/ready handshakes and a
// 2-entry skid buffer (output register plus one skid register).
module imm_decode_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 4,
    parameter bit EN_RV64I = (XLEN == 64)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_pc,
    output logic [TAG_W-1:0] out_tag
);

    if (!((XLEN == 32) || (XLEN == 64))) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    // Entry layout: {imm, fmt, illegal, pc, tag}
    localparam int ENT_W = XLEN + 3 + 1 + XLEN + TAG_W;

    logic [XLEN-1:0]  ext_imm_s;
    logic [2:0]       ext_fmt_s;
    logic             ext_ill_s;
    logic [ENT_W-1:0] new_ent_s;
    logic             accept_s;
    logic             drain_s;

    state_e           state_q,     state_d;
    logic [ENT_W-1:0] out_ent_q,   out_ent_d;
    logic [ENT_W-1:0] skid_ent_q,  skid_ent_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;

    imm_extract #(
        .XLEN     (XLEN),
        .EN_RV64I (EN_RV64I)
    ) u_extract (
        .instr_i   (in_instr),
        .imm_o     (ext_imm_s),
        .fmt_o     (ext_fmt_s),
        .illegal_o (ext_ill_s)
    );

    assign new_ent_s = {ext_imm_s, ext_fmt_s, ext_ill_s, in_pc, in_tag};
    assign accept_s  = in_valid && in_ready_q;
    assign drain_s   = out_valid_q && out_ready;

    // Held-entry count transitions and entry movement between the registers.
    always_comb begin
        state_d    = state_q;
        out_ent_d  = out_ent_q;
        skid_ent_d = skid_ent_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d   = ST_ONE;
                        out_ent_d = new_ent_s;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        out_ent_d = new_ent_s;
                    end else if (accept_s) begin
                        state_d    = ST_FULL;
                        skid_ent_d = new_ent_s;
                    end else if (drain_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (drain_s) begin
                        state_d   = ST_ONE;
                        out_ent_d = skid_ent_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State, handshake flags and entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_ent_q   <= '0;
            skid_ent_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_ent_q   <= out_ent_d;
            skid_ent_q  <= skid_ent_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_ent_q[ENT_W-1 -: XLEN];
    assign out_fmt     = out_ent_q[XLEN+TAG_W+1 +: 3];
    assign out_illegal = out_ent_q[XLEN+TAG_W];
    assign out_pc      = out_ent_q[TAG_W +: XLEN];
    assign out_tag     = out_ent_q[TAG_W-1:0];

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed decode checks, backpressure, flush and
// reset cases plus random traffic against an arithmetic reference model.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    // XLEN=32 instance
    logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_imm, out_pc;
    logic [3:0]  in_tag, out_tag;
    logic [2:0]  out_fmt;
    // XLEN=64 instance
    logic        v64, rdy64, ov64, ill64, flush64;
    logic [31:0] instr64;
    logic [63:0] pc64, imm64, opc64;
    logic [3:0]  tag64, otag64;
    logic [2:0]  fmt64;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] pc;
        logic [3:0]  tag;
    } exp_t;

    exp_t q[$];
    int   drained_tags[$];

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_pc(out_pc), .out_tag(out_tag)
    );

    logic ir64;
    imm_decode_stage #(.XLEN(64), .TAG_W(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64), .in_valid(v64),
        .in_ready(ir64), .in_instr(instr64), .in_pc(pc64), .in_tag(tag64),
        .out_valid(ov64), .out_ready(rdy64), .out_imm(imm64),
        .out_fmt(fmt64), .out_illegal(ill64), .out_pc(opc64), .out_tag(otag64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
        return (longint'(w) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    // Reference decode written as field arithmetic on the instruction word.
    task automatic ref_model(input int xlen, input logic [31:0] ins,
                             output logic [63:0] imm, output logic [2:0] fmt,
                             output logic ill);
        longint v, sgn;
        int     op, f3;
        bit     shift;
        op    = int'(fld(ins, 6, 0));
        f3    = int'(fld(ins, 14, 12));
        sgn   = fld(ins, 31, 31);
        shift = (f3 == 1) || (f3 == 5);
        v = 0; fmt = 3'd0; ill = 1'b0;
        if (op == 'h13 || op == 'h03 || op == 'h67 || (op == 'h1B && xlen == 64)) begin
            if ((op == 'h13 || op == 'h1B) && shift) begin
                fmt = 3'd6;
                if (op == 'h13) v = fld(ins, 25, 20);
                else            v = fld(ins, 24, 20);
                ill = (op == 'h1B || xlen == 32) && (fld(ins, 25, 25) == 1);
            end else begin
                fmt = 3'd1;
                v = fld(ins, 31, 20) - sgn * 4096;
            end
        end else if (op == 'h23) begin
            fmt = 3'd2;
            v = fld(ins, 31, 25) * 32 + fld(ins, 11, 7) - sgn * 4096;
        end else if (op == 'h63) begin
            fmt = 3'd3;
            v = sgn * 4096 + fld(ins, 7, 7) * 2048 + fld(ins, 30, 25) * 32
                + fld(ins, 11, 8) * 2 - sgn * 8192;
        end else if (op == 'h6F) begin
            fmt = 3'd5;
            v = sgn * (1 << 20) + fld(ins, 19, 12) * 4096 + fld(ins, 20, 20) * 2048
                + fld(ins, 30, 21) * 2 - sgn * (1 << 21);
        end else if (op == 'h37 || op == 'h17) begin
            fmt = 3'd4;
            v = fld(ins, 31, 12) * 4096 - sgn * (longint'(1) << 32);
        end else if (op == 'h73) begin
            if (f3 >= 4) begin
                fmt = 3'd7;
                v = fld(ins, 19, 15);
            end
        end else if (op == 'h33 || op == 'h0F || (op == 'h3B && xlen == 64)) begin
            v = 0;
        end else begin
            ill = 1'b1;
        end
        imm = 64'(v) & ((xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [14];
        logic [31:0] r;
        ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h6F,
                7'h37, 7'h17, 7'h73, 7'h33, 7'h0F, 7'h3B, 7'h7F};
        r = $urandom;
        if ($urandom_range(0, 9) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 13)]};
    endfunction

    // One cycle of the XLEN=32 instance, checked against the scoreboard.
    task automatic tick();
        bit   acc, drn;
        exp_t e;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        check("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
        check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        if (q.size() != 0) begin
            check("imm", {32'd0, out_imm}, q[0].imm);
            check("fmt", {61'd0, out_fmt}, {61'd0, q[0].fmt});
            check("illegal", {63'd0, out_illegal}, {63'd0, q[0].ill});
            check("pc", {32'd0, out_pc}, {32'd0, q[0].pc});
            check("tag", {60'd0, out_tag}, {60'd0, q[0].tag});
        end
        if (drn) drained_tags.push_back(int'(out_tag));
        ref_model(32, in_instr, e.imm, e.fmt, e.ill);
        e.pc  = in_pc;
        e.tag = in_tag;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (drn && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic send_directed(input logic [31:0] ins, input logic [63:0] imm,
                                 input logic [2:0] fmt, input logic ill, input string nm);
        in_instr = ins; in_valid = 1'b1; out_ready = 1'b1;
        in_pc = $urandom; in_tag = 4'($urandom);
        tick();
        in_valid = 1'b0;
        check({nm, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({nm, "_imm"}, {32'd0, out_imm}, imm);
        check({nm, "_fmt"}, {61'd0, out_fmt}, {61'd0, fmt});
        check({nm, "_ill"}, {63'd0, out_illegal}, {63'd0, ill});
        tick();
    endtask

    initial begin
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        int          exp_tags[$];
        bit          sent_now;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 32'd0; in_tag = 4'd0;
        v64 = 1'b0; rdy64 = 1'b1; flush64 = 1'b0; instr64 = 32'd0; pc64 = 64'd0; tag64 = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_imm", {32'd0, out_imm}, 64'd0);
        check("rst_fmt", {61'd0, out_fmt}, 64'd0);
        check("rst_ill", {63'd0, out_illegal}, 64'd0);
        check("rst_pc", {32'd0, out_pc}, 64'd0);
        check("rst_tag", {60'd0, out_tag}, 64'd0);
        check("rst64_valid", {63'd0, ov64}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed decode cases on XLEN=32
        send_directed(32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 1'b0, "addi_m1");
        send_directed(32'hFE000EE3, 64'hFFFF_FFFC, 3'd3, 1'b0, "beq_m4");
        send_directed(32'h300FD073, 64'h0000_001F, 3'd7, 1'b0, "csrrwi");
        send_directed(32'h02009093, 64'h0000_0020, 3'd6, 1'b1, "slli32");
        send_directed(32'h0000007F, 64'h0000_0000, 3'd0, 1'b1, "bad_op");
        send_directed(32'h0000001B, 64'h0000_0000, 3'd0, 1'b1, "opimm32_rv32");

        // Backpressure: tags 1,2,3 with out_ready low
        drained_tags.delete();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int t = 1; t <= 2; t++) begin
            in_tag = 4'(t); in_instr = rand_instr(); in_pc = $urandom;
            tick();
        end
        in_tag = 4'd3; in_instr = rand_instr(); in_pc = $urandom;
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        tick();
        out_ready = 1'b1;
        sent_now = 1'b0;
        for (int k = 0; k < 6 && !sent_now; k++) begin
            sent_now = in_ready;
            tick();
        end
        check("bp_tag3_accepted", {63'd0, sent_now}, 64'd1);
        in_valid = 1'b0;
        repeat (4) tick();
        exp_tags = '{1, 2, 3};
        check("bp_drain_count", 64'(drained_tags.size()), 64'd3);
        for (int k = 0; k < 3 && k < drained_tags.size(); k++)
            check("bp_order", 64'(drained_tags[k]), 64'(exp_tags[k]));

        // Flush while FULL, together with an incoming instruction
        out_ready = 1'b0; in_valid = 1'b1;
        for (int t = 4; t <= 5; t++) begin
            in_tag = 4'(t); in_instr = rand_instr(); in_pc = $urandom;
            tick();
        end
        in_tag = 4'hF; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        drained_tags.delete();
        out_ready = 1'b1; in_valid = 1'b1; in_tag = 4'd6; in_instr = rand_instr();
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("flush_drain_count", 64'(drained_tags.size()), 64'd1);
        if (drained_tags.size() != 0)
            check("flush_next_tag", 64'(drained_tags[0]), 64'd6);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            in_tag    = 4'($urandom);
            tick();
        end
        flush = 1'b0;

        // Asynchronous reset in the middle of traffic
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hFFF00093; in_tag = 4'd9;
        repeat (2) tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_imm", {32'd0, out_imm}, 64'd0);
        check("arst_tag", {60'd0, out_tag}, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        tick();

        // XLEN=64 instance: LUI then random decodes, one per cycle
        v64 = 1'b1; rdy64 = 1'b1;
        instr64 = 32'h800000B7; pc64 = 64'h1234_5678_9ABC_DEF0; tag64 = 4'd5;
        @(posedge clk); @(negedge clk);
        check("lui64_valid", {63'd0, ov64}, 64'd1);
        check("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
        check("lui64_fmt", {61'd0, fmt64}, 64'd4);
        check("lui64_pc", opc64, 64'h1234_5678_9ABC_DEF0);
        for (int c = 0; c < 60; c++) begin
            logic [31:0] ins;
            ins = rand_instr();
            if (c < 4) ins = {7'($urandom), 5'($urandom), 5'($urandom), 3'b001, 5'($urandom), 7'h1B};
            instr64 = ins; pc64 = {$urandom, $urandom}; tag64 = 4'($urandom);
            ref_model(64, ins, e_imm, e_fmt, e_ill);
            @(posedge clk); @(negedge clk);
            check("r64_valid", {63'd0, ov64}, 64'd1);
            check("r64_imm", imm64, e_imm);
            check("r64_fmt", {61'd0, fmt64}, {61'd0, e_fmt});
            check("r64_ill", {63'd0, ill64}, {63'd0, e_ill});
            check("r64_pc", opc64, pc64);
            check("r64_tag", {60'd0, otag64}, {60'd0, tag64});
        end
        v64 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
